// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and state encoding for the Sobel window sequencer
package sobel_pkg;

  localparam int PIXEL_BITS   = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int COORD_BITS   = 16;

  typedef logic [2:0] seqStateT;

  localparam seqStateT ST_IDLE     = 3'd0;
  localparam seqStateT ST_FETCH    = 3'd1;
  localparam seqStateT ST_LOAD     = 3'd2;
  localparam seqStateT ST_SHIFT    = 3'd3;
  localparam seqStateT ST_LINE_END = 3'd4;
  localparam seqStateT ST_DONE     = 3'd5;

  function automatic int wordsPerRow(input int imgWidth);
    return imgWidth / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/sobel_shift_sequencer_if.sv
// rtl/sobel_shift_sequencer_if.sv - line-buffer read and window-shifter control bus
interface sobel_shift_sequencer_if import sobel_pkg::*; #(
  parameter int ADDRW = 9
);
  logic                  out_ready;
  logic                  rd_en;
  logic [ADDRW-1:0]      rd_addr;
  logic                  load;
  logic                  shift;
  logic                  win_valid;
  logic [COORD_BITS-1:0] row;
  logic [COORD_BITS-1:0] col;

  modport master (
    input  out_ready,
    output rd_en, rd_addr, load, shift, win_valid, row, col
  );

  modport slave (
    output out_ready,
    input  rd_en, rd_addr, load, shift, win_valid, row, col
  );
endinterface

// File: rtl/sobel_beat_timer.sv
// rtl/sobel_beat_timer.sv - shared counter for shift beats within a word and the row-end pause
module sobel_beat_timer #(
  parameter int BEATS = 3,
  parameter int PAUSE = 1,
  parameter int CNTW  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic beatLast,
  output logic pauseLast
);
  logic [CNTW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Beats and pause never overlap, so one counter serves both phases.
  assign beatLast  = (count == CNTW'(BEATS - 1));
  assign pauseLast = (count == CNTW'(PAUSE - 1));
endmodule

// File: rtl/sobel_shift_sequencer.sv
// rtl/sobel_shift_sequencer.sv - walks a frame word by word, driving line-buffer reads and shifter load/shift
module sobel_shift_sequencer import sobel_pkg::*; #(
  parameter int IMG_WIDTH  = 2048,
  parameter int IMG_HEIGHT = 2048,
  parameter int BEATS      = 3,
  parameter int PAUSE      = 1,
  parameter int ADDRW      = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic frame_done,
  sobel_shift_sequencer_if.master bus
);
  localparam int WORDS = wordsPerRow(IMG_WIDTH);
  localparam int CNTW  = $clog2(((BEATS > PAUSE) ? BEATS : PAUSE) + 1);

  seqStateT              state;
  logic                  rdEn;
  logic [ADDRW-1:0]      rdAddr;
  logic [ADDRW-1:0]      wordCnt;
  logic                  loadR;
  logic                  shiftR;
  logic                  winValid;
  logic                  busyR;
  logic                  frameDone;
  logic [COORD_BITS-1:0] rowR;
  logic [COORD_BITS-1:0] colR;
  logic [COORD_BITS-1:0] pixCnt;
  logic                  timerClr;
  logic                  timerInc;
  logic                  beatLast;
  logic                  pauseLast;
  logic                  outReady;

  assign outReady = bus.out_ready;

  sobel_beat_timer #(
    .BEATS(BEATS),
    .PAUSE(PAUSE),
    .CNTW (CNTW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timerClr),
    .inc      (timerInc),
    .beatLast (beatLast),
    .pauseLast(pauseLast)
  );

  always_comb begin
    timerClr = 1'b1;
    timerInc = 1'b0;
    if (!abort) begin
      case (state)
        ST_SHIFT: begin
          timerClr = outReady && beatLast;
          timerInc = outReady && !beatLast;
        end
        ST_LINE_END: begin
          timerClr = pauseLast;
          timerInc = !pauseLast;
        end
        default: ;
      endcase
    end
  end

  // Strobes are registered: each one describes the action the datapath takes on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rdEn      <= 1'b0;
      rdAddr    <= '0;
      wordCnt   <= '0;
      loadR     <= 1'b0;
      shiftR    <= 1'b0;
      winValid  <= 1'b0;
      busyR     <= 1'b0;
      frameDone <= 1'b0;
      rowR      <= '0;
      colR      <= '0;
      pixCnt    <= '0;
    end else begin
      rdEn      <= 1'b0;
      loadR     <= 1'b0;
      shiftR    <= 1'b0;
      winValid  <= 1'b0;
      frameDone <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busyR <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state   <= ST_FETCH;
              busyR   <= 1'b1;
              rowR    <= '0;
              colR    <= '0;
              pixCnt  <= '0;
              wordCnt <= '0;
              rdEn    <= 1'b1;
              rdAddr  <= '0;
            end
          end
          ST_FETCH: state <= ST_LOAD;
          ST_LOAD: begin
            if (outReady) begin
              loadR    <= 1'b1;
              colR     <= pixCnt;
              pixCnt   <= pixCnt + 1'b1;
              winValid <= (rowR >= COORD_BITS'(2)) && (pixCnt >= COORD_BITS'(2));
              state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (outReady) begin
              shiftR   <= 1'b1;
              colR     <= pixCnt;
              pixCnt   <= pixCnt + 1'b1;
              winValid <= (rowR >= COORD_BITS'(2)) && (pixCnt >= COORD_BITS'(2));
              if (beatLast) begin
                if (wordCnt != ADDRW'(WORDS - 1)) begin
                  wordCnt <= wordCnt + 1'b1;
                  rdEn    <= 1'b1;
                  rdAddr  <= wordCnt + 1'b1;
                  state   <= ST_LOAD;
                end else begin
                  wordCnt <= '0;
                  state   <= ST_LINE_END;
                end
              end
            end
          end
          ST_LINE_END: begin
            if (pauseLast) begin
              colR   <= '0;
              pixCnt <= '0;
              if (rowR == COORD_BITS'(IMG_HEIGHT - 1)) begin
                state     <= ST_DONE;
                frameDone <= 1'b1;
                busyR     <= 1'b0;
              end else begin
                rowR   <= rowR + 1'b1;
                state  <= ST_FETCH;
                rdEn   <= 1'b1;
                rdAddr <= '0;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rd_en     = rdEn;
  assign bus.rd_addr   = rdAddr;
  assign bus.load      = loadR;
  assign bus.shift     = shiftR;
  assign bus.win_valid = winValid;
  assign bus.row       = rowR;
  assign bus.col       = colR;
  assign busy          = busyR;
  assign frame_done    = frameDone;
endmodule

// File: tb/tb_sobel_shift_sequencer.sv
// tb/tb_sobel_shift_sequencer.sv - scoreboard bench for the Sobel window sequencer
module tb_sobel_shift_sequencer;
  localparam int W     = 8;
  localparam int H     = 3;
  localparam int BEATS = 3;
  localparam int PAUSE = 1;
  localparam int ADDRW = 9;
  localparam int PPW   = 4;

  typedef struct packed {
    logic        isLoad;
    logic [15:0] row;
    logic [15:0] col;
    logic        wv;
  } pixEvT;

  typedef struct packed {
    logic [15:0]      row;
    logic [ADDRW-1:0] addr;
  } rdEvT;

  logic clk = 1'b0;
  logic reset;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic frame_done;

  sobel_shift_sequencer_if #(.ADDRW(ADDRW)) bus();

  sobel_shift_sequencer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .BEATS     (BEATS),
    .PAUSE     (PAUSE),
    .ADDRW     (ADDRW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .frame_done(frame_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  pixEvT pixQ[$];
  rdEvT  rdQ[$];
  int    doneQ[$];

  int total = 0;
  int bad   = 0;
  int nLoad = 0, nShift = 0, nRd = 0, nWv = 0, nDone = 0;
  int readyMode = 0;
  int stallReq = 0, stallSeen = 0, stallLeft = 0;
  logic lastReady = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h need 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void failNow(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h need 0x%0h", name, act, exp);
  endfunction

  // Reference: every row reads words 0..W/4-1; each word yields one load then shifts, one pixel per strobe.
  task automatic pushFrame();
    for (int r = 0; r < H; r++) begin
      for (int w = 0; w < W / PPW; w++) begin
        rdEvT re;
        re.row  = 16'(r);
        re.addr = ADDRW'(w);
        rdQ.push_back(re);
        for (int p = 0; p < PPW; p++) begin
          pixEvT e;
          e.isLoad = (p == 0);
          e.row    = 16'(r);
          e.col    = 16'(w * PPW + p);
          e.wv     = (r >= 2) && (w * PPW + p >= 2);
          pixQ.push_back(e);
        end
      end
    end
    doneQ.push_back(1);
  endtask

  task automatic flushModel();
    pixQ.delete();
    rdQ.delete();
    doneQ.delete();
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stallReq != stallSeen) begin
        stallSeen = stallReq;
        stallLeft = 5;
      end
      if (stallLeft > 0) begin
        bus.out_ready = 1'b0;
        stallLeft--;
      end else begin
        bus.out_ready = (readyMode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.load || bus.shift) begin
          nLoad  += int'(bus.load);
          nShift += int'(bus.shift);
          check("strobe_after_ready", lastReady, 1);
          if (pixQ.size() == 0) begin
            failNow("pix_extra", {bus.load, bus.shift, bus.row, bus.col}, 0);
          end else begin
            pixEvT e;
            e = pixQ.pop_front();
            check("pix_event", {bus.load, bus.shift, bus.row, bus.col, bus.win_valid},
                  {e.isLoad, !e.isLoad, e.row, e.col, e.wv});
          end
        end else begin
          if (bus.win_valid) failNow("wv_without_strobe", bus.win_valid, 0);
        end
        if (bus.win_valid) nWv++;
        if (bus.rd_en) begin
          nRd++;
          if (rdQ.size() == 0) begin
            failNow("rd_extra", {bus.row, bus.rd_addr}, 0);
          end else begin
            rdEvT re;
            re = rdQ.pop_front();
            check("rd_event", {bus.row, bus.rd_addr}, {re.row, re.addr});
          end
        end
        if (frame_done) begin
          nDone++;
          if (doneQ.size() == 0) begin
            failNow("done_extra", frame_done, 0);
          end else begin
            void'(doneQ.pop_front());
            check("done_busy_low", busy, 0);
          end
        end
      end
      lastReady = bus.out_ready;
    end
  end

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitEvent(input int kind, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      case (kind)
        0:       hit = bus.load;
        1:       hit = (bus.row == 16'd1) && bus.load;
        default: hit = (bus.row == 16'd1) && bus.shift;
      endcase
    end
    if (!hit) failNow(name, 0, 1);
  endtask

  task automatic waitDone(input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = frame_done;
    end
    if (!hit) failNow({name, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    check({name, "_pixq_empty"}, pixQ.size(), 0);
    check({name, "_rdq_empty"}, rdQ.size(), 0);
    check({name, "_doneq_empty"}, doneQ.size(), 0);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int sLoad, sShift, sRd, sWv, sDone;
    reset = 1'b1;
    #2 reset = 1'b0;
    #20;
    check("reset_outputs", {bus.rd_en, bus.rd_addr, bus.load, bus.shift, bus.win_valid,
                            bus.row, bus.col, busy, frame_done}, 0);
    @(negedge clk);
    reset = 1'b1;

    // Frame 1: always ready, exact strobe counts.
    readyMode = 0;
    sLoad = nLoad; sShift = nShift; sRd = nRd; sWv = nWv; sDone = nDone;
    pushFrame();
    pulseStart();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    waitDone("frame1");
    check("f1_loads",  nLoad - sLoad,   H * (W / PPW));
    check("f1_shifts", nShift - sShift, H * (W / PPW) * (PPW - 1));
    check("f1_reads",  nRd - sRd,       H * (W / PPW));
    check("f1_wv",     nWv - sWv,       (H - 2) * (W - 2));
    check("f1_done",   nDone - sDone,   1);

    // Frame 2: random back-pressure.
    readyMode = 1;
    pushFrame();
    pulseStart();
    waitDone("frame2");

    // Frame 3: five-cycle stall inside SHIFT, then a start while busy.
    readyMode = 0;
    sShift = nShift;
    pushFrame();
    pulseStart();
    waitEvent(0, "stall_wait_load");
    stallReq++;
    @(posedge clk);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_quiet", {bus.load, bus.shift, bus.rd_en}, 0);
    end
    waitEvent(1, "busy_start_wait");
    pulseStart();
    @(negedge clk);
    check("busy_start_row", bus.row, 1);
    check("busy_start_busy", busy, 1);
    waitDone("frame3");
    check("f3_shifts", nShift - sShift, H * (W / PPW) * (PPW - 1));

    // Abort during row 1.
    readyMode = 1;
    pushFrame();
    pulseStart();
    waitEvent(2, "abort_wait");
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_idle", {bus.rd_en, bus.load, bus.shift, bus.win_valid, busy, frame_done}, 0);
    flushModel();
    sDone = nDone;
    repeat (20) @(negedge clk);
    check("abort_no_done", nDone - sDone, 0);
    check("abort_busy", busy, 0);

    pushFrame();
    pulseStart();
    waitDone("after_abort");

    // Asynchronous reset mid-SHIFT.
    pushFrame();
    pulseStart();
    waitEvent(2, "reset_wait");
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {bus.rd_en, bus.rd_addr, bus.load, bus.shift, bus.win_valid,
                                  bus.row, bus.col, busy, frame_done}, 0);
    flushModel();
    sDone = nDone;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_no_done", nDone - sDone, 0);

    readyMode = 0;
    pushFrame();
    pulseStart();
    waitDone("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
